// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: one buffered fetch entry
// holds the instruction word together with the PC it was fetched from.
package fetch_pkg;

  localparam int FETCH_DATA_WIDTH = 32;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// Circular buffer between fetch and decode. A flush from a taken branch
// empties the buffer in one cycle; there is no empty-to-output bypass.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [DATA_WIDTH-1:0]    out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high and flush is low; in_ready and out_valid depend only on the
  // registered level, never on the opposite side's valid/ready.

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   push;
  logic                   pop;
  fetch_entry_t           head_entry;

  assign in_ready   = (level_q != LVL_W'(DEPTH));
  assign out_valid  = (level_q != '0);
  assign level      = level_q;
  assign head_entry = mem_q[head_q];
  assign out_instr  = out_valid ? DATA_WIDTH'(head_entry.instr) : '0;
  assign out_pc     = out_valid ? DATA_WIDTH'(head_entry.pc) : '0;

  always_comb begin
    push    = in_valid && in_ready && !flush;
    pop     = out_valid && out_ready && !flush;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q].pc    = FETCH_DATA_WIDTH'(in_pc);
        mem_d[tail_q].instr = FETCH_DATA_WIDTH'(in_instr);
        tail_d              = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset: stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: a driver issues cycles, a negedge
// monitor checks the DUT against an expected-entry queue.
module tb_instr_fetch_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic [W-1:0]  in_instr  = '0;
  logic [W-1:0]  in_pc     = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_instr;
  logic [W-1:0]  out_pc;
  logic          out_ready = 1'b0;
  logic          flush     = 1'b0;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  instr_fetch_buffer #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .level     (level)
  );

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] pc);
    return {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, then back to idle
  task automatic cyc(input logic v, input logic [W-1:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      logic was_full;
      check("mon_level", 64'(level), 64'(exp_q.size()));
      check("mon_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("mon_in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() == 0) begin
        check("mon_empty_data", {out_pc, out_instr}, '0);
      end
      was_full = (exp_q.size() == DEPTH);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && exp_q.size() != 0) begin
          check("mon_pop_entry", {out_pc, out_instr}, exp_q.pop_front());
        end
        if (in_valid && !was_full) begin
          exp_q.push_back({in_pc, instr_of(in_pc)});
        end
      end
    end
  end

  initial begin
    // reset for two cycles
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);

    // fill to DEPTH, fifth push refused
    for (int k = 0; k < 4; k++) cyc(1'b1, W'(4 * k), 1'b0, 1'b0);
    check("fill_level", 64'(level), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    check("fill_5th_level", 64'(level), 64'd4);
    check("fill_head_pc", 64'(out_pc), 64'h0);

    // drain in order
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_level", 64'(level), 64'd0);

    // push while empty with out_ready: no bypass
    in_valid = 1'b1; in_pc = 32'h20; in_instr = instr_of(32'h20); out_ready = 1'b1;
    #2;
    check("nobypass_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("push_visible_pc", 64'(out_pc), 64'h20);
    for (int k = 1; k < 4; k++) cyc(1'b1, W'(32'h20 + 4 * k), 1'b0, 1'b0);
    check("full2_level", 64'(level), 64'd4);

    // full with push and pop: pop only
    cyc(1'b1, 32'h30, 1'b1, 1'b0);
    check("fullcc_level", 64'(level), 64'd3);
    check("fullcc_head", 64'(out_pc), 64'h24);
    cyc(1'b1, 32'h34, 1'b1, 1'b0);
    check("cc_level", 64'(level), 64'd3);

    // flush beats push and pop
    cyc(1'b1, 32'h38, 1'b1, 1'b1);
    check("flush_level", 64'(level), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_pc", 64'(out_pc), 64'd0);
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    check("post_flush_head", 64'(out_pc), 64'h40);
    check("post_flush_instr", 64'(out_instr), 64'(instr_of(32'h40)));
    cyc(1'b0, '0, 1'b1, 1'b0);

    // wrap: steady push/pop at level 1
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, W'(32'h100 + 4 * k), 1'b1, 1'b0);
      check("wrap_level", 64'(level), 64'd1);
      check("wrap_head", 64'(out_pc), 64'(32'h100 + 4 * k));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("wrap_done_level", 64'(level), 64'd0);

    // reset mid-operation overrides everything
    cyc(1'b1, 32'h200, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b1; in_pc = 32'h208; in_instr = instr_of(32'h208);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    cyc(1'b1, 32'h300, 1'b0, 1'b0);
    check("midrst_head", 64'(out_pc), 64'h300);
    cyc(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
